// File: rtl/biriscv_issue_sched_pkg.sv
// Shared definitions for the dual-issue scheduler: decoded-info bit positions,
// divider FSM encoding and the issue-stage register record.
package biriscv_issue_sched_pkg;

  localparam int INFO_W        = 9;
  localparam int INFO_INVALID  = 8;
  localparam int INFO_FAULT    = 7;
  localparam int INFO_EXEC     = 6;
  localparam int INFO_LSU      = 5;
  localparam int INFO_BRANCH   = 4;
  localparam int INFO_MUL      = 3;
  localparam int INFO_DIV      = 2;
  localparam int INFO_CSR      = 1;
  localparam int INFO_RD_VALID = 0;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [INFO_W-1:0] info;
  } issue_t;

  function automatic logic is_trap(input logic [INFO_W-1:0] info);
    return info[INFO_INVALID] | info[INFO_FAULT];
  endfunction

endpackage

// File: rtl/biriscv_issue_scoreboard.sv
// Pending-writeback register mask for long-latency results, with hazard
// lookups for the two decoded slots. x0 never reads as pending.
module biriscv_issue_scoreboard
  import biriscv_issue_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_valid_i,
  input  logic [4:0] set_rd_i,
  input  logic       clr0_valid_i,
  input  logic [4:0] clr0_rd_i,
  input  logic       clr1_valid_i,
  input  logic [4:0] clr1_rd_i,
  input  logic [4:0] rs1_0_i,
  input  logic [4:0] rs2_0_i,
  input  logic [4:0] rd_0_i,
  input  logic       rd_valid_0_i,
  input  logic [4:0] rs1_1_i,
  input  logic [4:0] rs2_1_i,
  input  logic [4:0] rd_1_i,
  input  logic       rd_valid_1_i,
  output logic       hazard0_o,
  output logic       hazard1_o
);

  logic [31:0] sb_q;
  logic [31:0] sb_d;

  function automatic logic lookup(input logic [31:0] sb, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic rd_valid);
    return ((rs1 != 5'd0) && sb[rs1]) ||
           ((rs2 != 5'd0) && sb[rs2]) ||
           (rd_valid && (rd != 5'd0) && sb[rd]);
  endfunction

  // Clears are applied first so a same-cycle set on the same rd wins.
  always_comb begin
    sb_d = sb_q;
    if (clr0_valid_i) sb_d[clr0_rd_i] = 1'b0;
    if (clr1_valid_i) sb_d[clr1_rd_i] = 1'b0;
    if (set_valid_i)  sb_d[set_rd_i]  = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign hazard0_o = lookup(sb_q, rs1_0_i, rs2_0_i, rd_0_i, rd_valid_0_i);
  assign hazard1_o = lookup(sb_q, rs1_1_i, rs2_1_i, rd_1_i, rd_valid_1_i);

endmodule

// File: rtl/biriscv_issue_sched.sv
// In-order dual-issue scheduler: picks the oldest slot for pipe A, pairs the
// younger slot onto pipe B when legal, and registers the issue stage.
module biriscv_issue_sched
  import biriscv_issue_sched_pkg::*;
#(
  parameter int unsigned SUPPORT_DUAL_ISSUE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slot0_valid_i,
  input  logic [31:0]       slot0_instr_i,
  input  logic [31:0]       slot0_pc_i,
  input  logic [INFO_W-1:0] slot0_info_i,
  output logic              slot0_accept_o,
  input  logic              slot1_valid_i,
  input  logic [31:0]       slot1_instr_i,
  input  logic [31:0]       slot1_pc_i,
  input  logic [INFO_W-1:0] slot1_info_i,
  output logic              slot1_accept_o,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_lsu_valid_i,
  input  logic [4:0]        wb_lsu_rd_i,
  input  logic              wb_muldiv_valid_i,
  input  logic [4:0]        wb_muldiv_rd_i,
  input  logic              div_complete_i,
  output logic              issue_a_valid_o,
  output logic [31:0]       issue_a_pc_o,
  output logic [31:0]       issue_a_instr_o,
  output logic [INFO_W-1:0] issue_a_info_o,
  output logic              issue_b_valid_o,
  output logic [31:0]       issue_b_pc_o,
  output logic [31:0]       issue_b_instr_o,
  output logic [INFO_W-1:0] issue_b_info_o,
  output logic              div_busy_o
);

  div_state_e div_state_q, div_state_d;
  issue_t     a_q, a_d, b_q, b_d;

  logic              hz0, hz1;
  logic              o_sel1, o_valid, o_hz, o_trap, o_wr, o_issue;
  logic [31:0]       o_instr, o_pc;
  logic [INFO_W-1:0] o_info;
  logic [4:0]        o_rd, y_rs1, y_rs2, y_rd;
  logic              y_valid, y_class_ok, y_dep, o_pairable, y_issue;
  logic              sb_set;

  // Oldest valid slot always targets pipe A.
  assign o_sel1  = !slot0_valid_i;
  assign o_valid = slot0_valid_i | slot1_valid_i;
  assign o_instr = o_sel1 ? slot1_instr_i : slot0_instr_i;
  assign o_pc    = o_sel1 ? slot1_pc_i    : slot0_pc_i;
  assign o_info  = o_sel1 ? slot1_info_i  : slot0_info_i;
  assign o_hz    = o_sel1 ? hz1 : hz0;
  assign o_trap  = is_trap(o_info);
  assign o_rd    = o_instr[11:7];
  assign o_wr    = o_info[INFO_RD_VALID] && (o_rd != 5'd0);

  assign o_issue = o_valid && !stall_i && !flush_i && (o_trap || !o_hz) &&
                   !((o_info[INFO_DIV] || o_info[INFO_MUL]) && div_busy_o);

  assign y_valid    = slot0_valid_i && slot1_valid_i;
  assign y_rs1      = slot1_instr_i[19:15];
  assign y_rs2      = slot1_instr_i[24:20];
  assign y_rd       = slot1_instr_i[11:7];
  assign y_class_ok = (slot1_info_i[INFO_EXEC] || slot1_info_i[INFO_BRANCH]) &&
                      !slot1_info_i[INFO_LSU] && !slot1_info_i[INFO_MUL] &&
                      !slot1_info_i[INFO_DIV] && !slot1_info_i[INFO_CSR] &&
                      !is_trap(slot1_info_i);
  assign y_dep      = o_wr && ((y_rs1 == o_rd) || (y_rs2 == o_rd) || (y_rd == o_rd));
  assign o_pairable = !o_info[INFO_BRANCH] && !o_info[INFO_CSR] && !o_trap;
  assign y_issue    = (SUPPORT_DUAL_ISSUE != 0) && o_issue && y_valid && o_pairable &&
                      y_class_ok && !hz1 && !y_dep;

  assign slot0_accept_o = o_issue && !o_sel1;
  assign slot1_accept_o = (o_issue && o_sel1) || y_issue;

  assign sb_set = o_issue && o_wr &&
                  (o_info[INFO_LSU] || o_info[INFO_MUL] || o_info[INFO_DIV]);

  biriscv_issue_scoreboard u_sb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_valid_i  (sb_set),
    .set_rd_i     (o_rd),
    .clr0_valid_i (wb_lsu_valid_i),
    .clr0_rd_i    (wb_lsu_rd_i),
    .clr1_valid_i (wb_muldiv_valid_i),
    .clr1_rd_i    (wb_muldiv_rd_i),
    .rs1_0_i      (slot0_instr_i[19:15]),
    .rs2_0_i      (slot0_instr_i[24:20]),
    .rd_0_i       (slot0_instr_i[11:7]),
    .rd_valid_0_i (slot0_info_i[INFO_RD_VALID]),
    .rs1_1_i      (y_rs1),
    .rs2_1_i      (y_rs2),
    .rd_1_i       (y_rd),
    .rd_valid_1_i (slot1_info_i[INFO_RD_VALID]),
    .hazard0_o    (hz0),
    .hazard1_o    (hz1)
  );

  always_comb begin
    div_state_d = div_state_q;
    unique case (div_state_q)
      DIV_IDLE: if (o_issue && o_info[INFO_DIV]) div_state_d = DIV_BUSY;
      DIV_BUSY: if (div_complete_i)              div_state_d = DIV_IDLE;
      default:                                   div_state_d = DIV_IDLE;
    endcase
  end

  // Flush kills the stage; stall freezes it; otherwise reload every cycle.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (flush_i) begin
      a_d.valid = 1'b0;
      b_d.valid = 1'b0;
    end else if (!stall_i) begin
      a_d.valid = o_issue;
      b_d.valid = y_issue;
      if (o_issue) begin
        a_d.pc    = o_pc;
        a_d.instr = o_instr;
        a_d.info  = o_info;
      end
      if (y_issue) begin
        b_d.pc    = slot1_pc_i;
        b_d.instr = slot1_instr_i;
        b_d.info  = slot1_info_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_state_q <= DIV_IDLE;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      div_state_q <= div_state_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign div_busy_o      = (div_state_q == DIV_BUSY);
  assign issue_a_valid_o = a_q.valid;
  assign issue_a_pc_o    = a_q.pc;
  assign issue_a_instr_o = a_q.instr;
  assign issue_a_info_o  = a_q.info;
  assign issue_b_valid_o = b_q.valid;
  assign issue_b_pc_o    = b_q.pc;
  assign issue_b_instr_o = b_q.instr;
  assign issue_b_info_o  = b_q.info;

endmodule

// File: tb/tb_biriscv_issue_sched.sv
// Directed bench for biriscv_issue_sched: the driver pushes expected issue
// records, a negedge monitor pops them when the issue stage reloads.
module tb_biriscv_issue_sched;

  localparam int W = 75;  // {a_v, a_pc[32], a_info[9], b_v, b_pc[32]}

  localparam logic [8:0] I_ALU   = 9'h041;
  localparam logic [8:0] I_LSU   = 9'h021;
  localparam logic [8:0] I_MUL   = 9'h009;
  localparam logic [8:0] I_DIV   = 9'h005;
  localparam logic [8:0] I_FAULT = 9'h080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_v = 1'b0, s1_v = 1'b0;
  logic [31:0] s0_instr = '0, s1_instr = '0, s0_pc = '0, s1_pc = '0;
  logic [8:0]  s0_info = '0, s1_info = '0;
  logic        acc0, acc1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        wb_lsu_v = 1'b0, wb_md_v = 1'b0, div_done = 1'b0;
  logic [4:0]  wb_lsu_rd = '0, wb_md_rd = '0;
  logic        a_v, b_v, div_busy;
  logic [31:0] a_pc, a_instr, b_pc, b_instr;
  logic [8:0]  a_info, b_info;

  logic [W-1:0] exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  loaded_q = 1'b0;

  biriscv_issue_sched #(.SUPPORT_DUAL_ISSUE(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .slot0_valid_i(s0_v), .slot0_instr_i(s0_instr), .slot0_pc_i(s0_pc),
    .slot0_info_i(s0_info), .slot0_accept_o(acc0),
    .slot1_valid_i(s1_v), .slot1_instr_i(s1_instr), .slot1_pc_i(s1_pc),
    .slot1_info_i(s1_info), .slot1_accept_o(acc1),
    .stall_i(stall), .flush_i(flush),
    .wb_lsu_valid_i(wb_lsu_v), .wb_lsu_rd_i(wb_lsu_rd),
    .wb_muldiv_valid_i(wb_md_v), .wb_muldiv_rd_i(wb_md_rd),
    .div_complete_i(div_done),
    .issue_a_valid_o(a_v), .issue_a_pc_o(a_pc), .issue_a_instr_o(a_instr),
    .issue_a_info_o(a_info),
    .issue_b_valid_o(b_v), .issue_b_pc_o(b_pc), .issue_b_instr_o(b_instr),
    .issue_b_info_o(b_info),
    .div_busy_o(div_busy)
  );

  // Clock / reset bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) loaded_q <= !rst && !stall && !flush;

  function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic [W-1:0] ex(input logic av, input logic [31:0] apc,
                                      input logic [8:0] ainfo, input logic bv,
                                      input logic [31:0] bpc);
    return {av, apc, ainfo, bv, bpc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set0(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [8:0] info);
    s0_v = v; s0_instr = instr; s0_pc = pc; s0_info = info;
  endtask

  task automatic set1(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [8:0] info);
    s1_v = v; s1_instr = instr; s1_pc = pc; s1_info = info;
  endtask

  // Check the combinational accepts for the current inputs, then clock once.
  task automatic step(input string nm, input logic e0, input logic e1);
    #1;
    chk({nm, " acc0"}, {31'd0, acc0}, {31'd0, e0});
    chk({nm, " acc1"}, {31'd0, acc1}, {31'd0, e1});
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && loaded_q && (a_v || b_v)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: a_v=%b a_pc=0x%0h b_v=%b b_pc=0x%0h",
                 a_v, a_pc, b_v, b_pc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("mon a_valid", {31'd0, a_v}, {31'd0, e[74]});
        if (e[74]) begin
          chk("mon a_pc", a_pc, e[73:42]);
          chk("mon a_info", {23'd0, a_info}, {23'd0, e[41:33]});
        end
        chk("mon b_valid", {31'd0, b_v}, {31'd0, e[32]});
        if (e[32]) chk("mon b_pc", b_pc, e[31:0]);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst a_valid", {31'd0, a_v}, 32'd0);
    chk("rst b_valid", {31'd0, b_v}, 32'd0);
    chk("rst a_pc", a_pc, 32'd0);
    chk("rst a_info", {23'd0, a_info}, 32'd0);
    chk("rst div_busy", {31'd0, div_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Independent pair dual-issues
    set0(1, r_op(5'd1, 5'd2, 5'd3), 32'h100, I_ALU);
    set1(1, r_op(5'd4, 5'd5, 5'd6), 32'h104, I_ALU);
    exp_q.push_back(ex(1, 32'h100, I_ALU, 1, 32'h104));
    step("pair", 1, 1);
    set0(0, '0, '0, '0); set1(0, '0, '0, '0);
    step("idle", 0, 0);

    // Load-use: blocked until lsu writeback, no same-cycle bypass
    set0(1, r_op(5'd5, 5'd1, 5'd0), 32'h200, I_LSU);
    exp_q.push_back(ex(1, 32'h200, I_LSU, 0, '0));
    step("lw", 1, 0);
    set0(1, r_op(5'd6, 5'd5, 5'd1), 32'h204, I_ALU);
    step("lu wait1", 0, 0);
    step("lu wait2", 0, 0);
    wb_lsu_v = 1; wb_lsu_rd = 5'd5;
    step("lu wb cycle", 0, 0);
    wb_lsu_v = 0;
    exp_q.push_back(ex(1, 32'h204, I_ALU, 0, '0));
    step("lu after wb", 1, 0);

    // RAW inside the pair splits it
    set0(1, r_op(5'd3, 5'd1, 5'd2), 32'h300, I_ALU);
    set1(1, r_op(5'd4, 5'd3, 5'd2), 32'h304, I_ALU);
    exp_q.push_back(ex(1, 32'h300, I_ALU, 0, '0));
    step("raw pair", 1, 0);
    set0(0, '0, '0, '0);
    exp_q.push_back(ex(1, 32'h304, I_ALU, 0, '0));
    step("slot1 alone", 0, 1);
    set1(0, '0, '0, '0);

    // Divider busy blocks mul until div_complete
    set0(1, r_op(5'd7, 5'd1, 5'd2), 32'h400, I_DIV);
    exp_q.push_back(ex(1, 32'h400, I_DIV, 0, '0));
    step("div", 1, 0);
    chk("div_busy set", {31'd0, div_busy}, 32'd1);
    set0(1, r_op(5'd8, 5'd9, 5'd10), 32'h404, I_MUL);
    step("mul wait1", 0, 0);
    step("mul wait2", 0, 0);
    div_done = 1;
    step("mul done cycle", 0, 0);
    div_done = 0;
    chk("div_busy clr", {31'd0, div_busy}, 32'd0);
    exp_q.push_back(ex(1, 32'h404, I_MUL, 0, '0));
    step("mul", 1, 0);
    set0(1, r_op(5'd13, 5'd8, 5'd0), 32'h408, I_ALU);
    step("mul dep wait", 0, 0);
    wb_md_v = 1; wb_md_rd = 5'd8;
    step("md wb cycle", 0, 0);
    wb_md_rd = 5'd7;
    exp_q.push_back(ex(1, 32'h408, I_ALU, 0, '0));
    step("mul dep go", 1, 0);
    wb_md_v = 0;
    set0(0, '0, '0, '0);
    div_done = 1;
    step("done in idle", 0, 0);
    div_done = 0;
    chk("div idle stays", {31'd0, div_busy}, 32'd0);

    // Stall holds, stall+flush kills, scoreboard survives flush
    set0(1, r_op(5'd5, 5'd1, 5'd0), 32'h500, I_LSU);
    exp_q.push_back(ex(1, 32'h500, I_LSU, 0, '0));
    step("lw2", 1, 0);
    set0(1, r_op(5'd11, 5'd1, 5'd2), 32'h504, I_ALU);
    exp_q.push_back(ex(1, 32'h504, I_ALU, 0, '0));
    step("add pre stall", 1, 0);
    set0(1, r_op(5'd12, 5'd1, 5'd2), 32'h508, I_ALU);
    stall = 1;
    step("stall", 0, 0);
    chk("stall hold a_v", {31'd0, a_v}, 32'd1);
    chk("stall hold a_pc", a_pc, 32'h504);
    flush = 1;
    step("stall+flush", 0, 0);
    stall = 0; flush = 0;
    chk("flush a_v", {31'd0, a_v}, 32'd0);
    chk("flush b_v", {31'd0, b_v}, 32'd0);
    set0(1, r_op(5'd12, 5'd5, 5'd0), 32'h50c, I_ALU);
    step("x5 still pending", 0, 0);
    wb_lsu_v = 1; wb_lsu_rd = 5'd5;
    step("x5 wb cycle", 0, 0);
    wb_lsu_v = 0;
    exp_q.push_back(ex(1, 32'h50c, I_ALU, 0, '0));
    step("x5 released", 1, 0);

    // Fault ignores hazards and issues alone
    set0(1, r_op(5'd14, 5'd1, 5'd0), 32'h5f0, I_LSU);
    exp_q.push_back(ex(1, 32'h5f0, I_LSU, 0, '0));
    step("lw x14", 1, 0);
    set0(1, r_op(5'd0, 5'd14, 5'd0), 32'h600, I_FAULT);
    set1(1, r_op(5'd15, 5'd1, 5'd2), 32'h604, I_ALU);
    exp_q.push_back(ex(1, 32'h600, I_FAULT, 0, '0));
    step("fault", 1, 0);
    set0(0, '0, '0, '0);
    exp_q.push_back(ex(1, 32'h604, I_ALU, 0, '0));
    step("after fault", 0, 1);
    set1(0, '0, '0, '0);
    wb_lsu_v = 1; wb_lsu_rd = 5'd14;
    step("drain", 0, 0);
    wb_lsu_v = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
